// File: rtl/gpgpu_launch_ctrl.sv
// Kernel launch sequencer: writes PC, three arguments and the launch word over the
// OBI configuration port, then polls the done register until completion or timeout.
module gpgpu_launch_ctrl #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int unsigned POLL_INTERVAL  = 16,
  parameter int unsigned TIMEOUT_CYCLES = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [31:0] kernel_pc_i,
  input  logic [31:0] arg0_i,
  input  logic [31:0] arg1_i,
  input  logic [31:0] arg2_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [31:0] status_o,
  output logic        conf_req_o,
  output logic        conf_we_o,
  output logic [3:0]  conf_be_o,
  output logic [31:0] conf_addr_o,
  output logic [31:0] conf_wdata_o,
  input  logic        conf_gnt_i,
  input  logic        conf_rvalid_i,
  input  logic [31:0] conf_rdata_i,
  output logic [2:0]  dbg_state_o
);

  // OBI handshake: a request (req with addr/we/wdata) is held stable until the cycle
  // gnt is seen high; its response is the first rvalid after that cycle, and no new
  // request is raised until that rvalid has been received.

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WR_REQ    = 3'd1,
    WR_RSP    = 3'd2,
    POLL_WAIT = 3'd3,
    RD_REQ    = 3'd4,
    RD_RSP    = 3'd5,
    FINISH    = 3'd6
  } state_t;

  localparam logic [31:0] POLL_LAST = 32'(POLL_INTERVAL - 1);
  localparam logic [31:0] TO_LIMIT  = 32'(TIMEOUT_CYCLES);
  localparam logic        TO_EN     = (TIMEOUT_CYCLES != 0);
  localparam logic [31:0] DONE_OFS  = 32'h20;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] arg0_q, arg0_d;
  logic [31:0] arg1_q, arg1_d;
  logic [31:0] arg2_q, arg2_d;
  logic [31:0] status_q, status_d;
  logic [31:0] poll_q, poll_d;
  logic [31:0] to_q, to_d;
  logic        err_q, err_d;

  logic        timed_out;
  logic        polling;
  logic [31:0] wr_ofs;
  logic [31:0] wr_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      idx_q    <= 3'd0;
      pc_q     <= 32'h0;
      arg0_q   <= 32'h0;
      arg1_q   <= 32'h0;
      arg2_q   <= 32'h0;
      status_q <= 32'h0;
      poll_q   <= 32'h0;
      to_q     <= 32'h0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      pc_q     <= pc_d;
      arg0_q   <= arg0_d;
      arg1_q   <= arg1_d;
      arg2_q   <= arg2_d;
      status_q <= status_d;
      poll_q   <= poll_d;
      to_q     <= to_d;
      err_q    <= err_d;
    end
  end

  // Write payload selected by the write index.
  always_comb begin
    wr_ofs  = 32'h1C;
    wr_data = 32'h1;
    case (idx_q)
      3'd0: begin wr_ofs = 32'h0C; wr_data = pc_q;   end
      3'd1: begin wr_ofs = 32'h10; wr_data = arg0_q; end
      3'd2: begin wr_ofs = 32'h14; wr_data = arg1_q; end
      3'd3: begin wr_ofs = 32'h18; wr_data = arg2_q; end
      default: begin wr_ofs = 32'h1C; wr_data = 32'h1; end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    pc_d     = pc_q;
    arg0_d   = arg0_q;
    arg1_d   = arg1_q;
    arg2_d   = arg2_q;
    status_d = status_q;
    poll_d   = poll_q;
    to_d     = to_q;
    err_d    = err_q;

    polling   = (state_q == POLL_WAIT) || (state_q == RD_REQ) || (state_q == RD_RSP);
    timed_out = TO_EN && (to_q >= TO_LIMIT);

    // Timeout budget counter saturates at the limit instead of wrapping.
    if (TO_EN && polling && !timed_out) begin
      to_d = to_q + 32'd1;
    end

    case (state_q)
      IDLE: begin
        if (start_i) begin
          pc_d     = kernel_pc_i;
          arg0_d   = arg0_i;
          arg1_d   = arg1_i;
          arg2_d   = arg2_i;
          status_d = 32'h0;
          idx_d    = 3'd0;
          err_d    = 1'b0;
          state_d  = WR_REQ;
        end
      end
      WR_REQ: begin
        if (conf_gnt_i) state_d = WR_RSP;
      end
      WR_RSP: begin
        if (conf_rvalid_i) begin
          if (idx_q < 3'd4) begin
            idx_d   = idx_q + 3'd1;
            state_d = WR_REQ;
          end else begin
            poll_d  = 32'h0;
            to_d    = 32'h0;
            state_d = POLL_WAIT;
          end
        end
      end
      POLL_WAIT: begin
        if (timed_out) begin
          err_d   = 1'b1;
          state_d = FINISH;
        end else if (poll_q == POLL_LAST) begin
          state_d = RD_REQ;
        end else begin
          poll_d = poll_q + 32'd1;
        end
      end
      RD_REQ: begin
        if (conf_gnt_i) state_d = RD_RSP;
      end
      RD_RSP: begin
        if (conf_rvalid_i) begin
          status_d = conf_rdata_i;
          // A response reporting done takes priority over an expired budget.
          if (conf_rdata_i[0]) begin
            err_d   = 1'b0;
            state_d = FINISH;
          end else if (timed_out) begin
            err_d   = 1'b1;
            state_d = FINISH;
          end else begin
            poll_d  = 32'h0;
            state_d = POLL_WAIT;
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy_o       = (state_q != IDLE) && (state_q != FINISH);
    done_o       = (state_q == FINISH) && !err_q;
    error_o      = (state_q == FINISH) && err_q;
    status_o     = status_q;
    conf_be_o    = 4'b1111;
    conf_req_o   = 1'b0;
    conf_we_o    = 1'b0;
    conf_addr_o  = 32'h0;
    conf_wdata_o = 32'h0;
    dbg_state_o  = state_q;
    if (state_q == WR_REQ) begin
      conf_req_o   = 1'b1;
      conf_we_o    = 1'b1;
      conf_addr_o  = BASE_ADDR + wr_ofs;
      conf_wdata_o = wr_data;
    end else if (state_q == RD_REQ) begin
      conf_req_o  = 1'b1;
      conf_addr_o = BASE_ADDR + DONE_OFS;
    end
  end

endmodule

// File: doc/gpgpu_launch_ctrl.md
# gpgpu_launch_ctrl

Host-side kernel launch sequencer for `gpgpu_top`. On a single start pulse it programs the GPGPU configuration registers over the OBI configuration port:

- kernel PC at 0x0C;
- three kernel arguments at 0x10/0x14/0x18;
- launch word 1 at 0x1C.

It then polls the done register at 0x20 until bit 0 is set, and reports completion or timeout to the host. It replaces hand-written register-write sequences and lets any host (core, bench, DMA) launch kernels with one handshake.

## Interface
Parameters:
- `BASE_ADDR`, 32'h0000_0000, base address of the GPGPU configuration register block; added to every offset.
- `POLL_INTERVAL`, 16, idle cycles between consecutive done-register reads (≥1).
- `TIMEOUT_CYCLES`, 0, cycle budget for the polling phase; 0 disables the timeout.

Ports:
- `clk_i`  in  1  clock. One clock domain.
- `rst_ni`  in  1  reset, asynchronous, active-low.
- `start_i`  in  1  launch request, sampled only in IDLE.
- `kernel_pc_i`  in  32  kernel start address, latched at start.
- `arg0_i`, `arg1_i`, `arg2_i`  in  32 each  kernel arguments, latched at start.
- `busy_o`  out  1  high from the cycle after an accepted start until the return to IDLE.
- `done_o`  out  1  one-cycle pulse on kernel completion.
- `error_o`  out  1  one-cycle pulse on poll timeout.
- `status_o`  out  32  last rdata read from the done register; held until the next start.
- `conf_req_o`  out  1  OBI request.
- `conf_we_o`  out  1  OBI write enable.
- `conf_be_o`  out  4  OBI byte enable; always 4'b1111.
- `conf_addr_o`  out  32  OBI address.
- `conf_wdata_o`  out  32  OBI write data.
- `conf_gnt_i`  in  1  OBI grant.
- `conf_rvalid_i`  in  1  OBI response valid.
- `conf_rdata_i`  in  32  OBI read data.

## Operation
- States: IDLE, WR_REQ, WR_RSP, POLL_WAIT, RD_REQ, RD_RSP, FINISH.
- IDLE:
  - On `start_i`, latch PC and the three arguments, clear `status_o`, set write index 0, and go to WR_REQ.
  - `start_i` in any other state is ignored; there is no queueing.
- WR_REQ:
  - Drive `req`=1, `we`=1, `addr`=BASE_ADDR+offset[idx], `wdata`=data[idx].
  - Offset and data by index: 0 → 0x0C/PC; 1 → 0x10/arg0; 2 → 0x14/arg1; 3 → 0x18/arg2; 4 → 0x1C/32'h1.
  - Request and payload stay stable until `gnt`. On `gnt`, drop `req` the next cycle and go to WR_RSP.
- WR_RSP:
  - Wait for `rvalid`.
  - Then, if idx<4, increment idx and go to WR_REQ. If idx==4, clear the poll counter and timeout counter and go to POLL_WAIT.
- POLL_WAIT: count POLL_INTERVAL cycles, then go to RD_REQ.
- RD_REQ: `req`=1, `we`=0, `addr`=BASE_ADDR+0x20, `wdata`=0. Held until `gnt`, then go to RD_RSP.
- RD_RSP: on `rvalid`, capture `conf_rdata_i` into `status_o`.
  - If bit 0 is set, go to FINISH with `done`.
  - Otherwise, go to POLL_WAIT.
- Timeout:
  - The counter runs in POLL_WAIT/RD_REQ/RD_RSP when TIMEOUT_CYCLES≠0. It saturates and never wraps.
  - On reaching TIMEOUT_CYCLES, mark timeout. Any outstanding read completes its `gnt`/`rvalid` handshake normally, then go to FINISH with `error`.
  - If the same response shows done, `done` wins and no error is raised.
- FINISH: pulse `done_o` or `error_o` for exactly one cycle, deassert `busy_o`, and return to IDLE.
- OBI rules:
  - At most one transaction outstanding.
  - A new `req` is never raised before the `rvalid` of the previous transaction.
  - `rvalid` without an outstanding transaction is ignored.
  - `be` is always 4'b1111.
- Reset mid-operation: all state is cleared asynchronously and `conf_req_o` drops immediately. The slave-side transaction is abandoned; a late `rvalid` is ignored in IDLE.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `error_o`=0, `status_o`=0, `conf_req_o`=0, `conf_we_o`=0, `conf_be_o`=4'b1111, `conf_addr_o`=0, `conf_wdata_o`=0.
- `start_i` is sampled at edge N. `busy_o` and the first `conf_req_o` are high from N+1.
- With zero-wait `gnt` and `rvalid` one cycle after `gnt`, each write takes 2 cycles, so the five writes take 10 cycles.
- The first read `req` is asserted POLL_INTERVAL cycles after the last write's `rvalid`.
- `done_o` pulses the cycle after the `rvalid` carrying bit 0 = 1. `busy_o` falls in the same cycle.
- A new start is accepted in the cycle after FINISH, giving back-to-back launches.

## Test plan
- Zero-wait slave. PC=0x8000, args=0, done set on the 3rd read → exact write sequence 0x0C:0x8000, 0x10:0, 0x14:0, 0x18:0, 0x1C:1; three reads of 0x20; `done_o` is one cycle; `status_o`=1; `busy_o` spans start+1 to FINISH.
- Random `gnt` stalls of 0–5 cycles and `rvalid` delays of 1–4 cycles → address/wdata stable while `req` high without `gnt`; never two outstanding; same write order and data.
- TIMEOUT_CYCLES=100, done never set → `error_o` pulses once ~100 cycles after polling starts, `done_o` stays 0, and the in-flight read completes before IDLE.
- `start_i` held high throughout a launch, plus new arg values mid-sequence → exactly one launch uses the latched values; a second launch starts right after FINISH.
- `rst_ni` asserted while WR_REQ waits for `gnt` → `conf_req_o` low asynchronously; all outputs at reset values; a following start produces a clean full sequence.
- BASE_ADDR=0x2000_0000, POLL_INTERVAL=1 → addresses 0x2000_000C to 0x2000_0020; exactly 1 idle cycle between read responses and the next read `req`.
